xor_puf_ctrl_n: RTL and testbench

Parametrised N-channel XOR-PUF stimulus and capture controller, successor to the single-channel XOR controller in the SPI/XOR_PUF_STIMULI test path. Sits between the SPI command decoder (CODE, CNT_VAL, REP_VAL, CH_MASK) and an array of XOR-PUF instances. Drives per-channel reset/launch/evaluate stimuli, captures each channel's response, and runs a repeat mode. Repeat mode re-evaluates the same PUFs and accumulates an unstable-bit mask for reliability measurement.

---
 rtl/xor_puf_ctrl_n.sv | 170 +++++++++++++++++
 tb/tb_xor_puf_ctrl_n.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/xor_puf_ctrl_n.sv
// N-channel XOR-PUF stimulus/capture controller: RST -> LAUNCH -> EVAL -> SAMPLE per evaluation,
// RST_CYC+2*CNT_VAL+1 cycles each; no backpressure, results held in DONE until CODE==4.
module xor_puf_ctrl_n #(
  parameter int N_CH    = 4,
  parameter int RESP_W  = 32,
  parameter int CNT_W   = 16,
  parameter int RST_CYC = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [7:0]               CODE,
  input  logic [CNT_W-1:0]         CNT_VAL,
  input  logic [7:0]               REP_VAL,
  input  logic [N_CH-1:0]          CH_MASK,
  input  logic [N_CH*RESP_W-1:0]   PUF_OUT,
  output logic [N_CH-1:0]          RESET_XOR,
  output logic [N_CH-1:0]          I1_XOR,
  output logic [N_CH-1:0]          I2_XOR,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic [7:0]               EVAL_CNT,
  output logic [N_CH*RESP_W-1:0]   PUF_OUT_REG,
  output logic [N_CH*RESP_W-1:0]   UNSTABLE
);

  localparam int RW = N_CH*RESP_W;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC-1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_LAUNCH, S_EVAL, S_SAMPLE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d, cnt_q, cnt_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [7:0]       target_q, target_d, eval_d;
  logic [RW-1:0]    ref_d, unst_d, mask_bits;
  logic             done_d, err_d, busy_d, err_pend_q, err_pend_d;
  logic [N_CH-1:0]  rst_x_d, i1_d, i2_d;
  logic             start;

  for (genvar g = 0; g < N_CH; g++) begin : g_mask
    assign mask_bits[g*RESP_W +: RESP_W] = {RESP_W{mask_q[g]}};
  end

  assign start = (CODE == 8'd2) || (CODE == 8'd3);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    target_d   = target_q;
    eval_d     = EVAL_CNT;
    ref_d      = PUF_OUT_REG;
    unst_d     = UNSTABLE;
    done_d     = DONE;
    err_d      = ERR;
    err_pend_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A rejected start is reported one cycle later, without ever raising BUSY.
        if (err_pend_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (start) begin
          cnt_d    = CNT_VAL;
          mask_d   = CH_MASK;
          target_d = (CODE == 8'd3 && REP_VAL != 8'd0) ? REP_VAL : 8'd1;
          if (CNT_VAL == '0 || CH_MASK == '0) begin
            err_pend_d = 1'b1;
          end else begin
            eval_d  = 8'd0;
            ref_d   = '0;
            unst_d  = '0;
            state_d = S_RST;
            phase_d = RST_LAST;
          end
        end
      end
      S_RST: begin
        phase_d = phase_q - ONE;
        if (phase_q == '0) begin
          state_d = S_LAUNCH;
          phase_d = cnt_q - ONE;
        end
      end
      S_LAUNCH: begin
        phase_d = phase_q - ONE;
        if (phase_q == '0) begin
          state_d = S_EVAL;
          phase_d = cnt_q - ONE;
        end
      end
      S_EVAL: begin
        phase_d = phase_q - ONE;
        if (phase_q == '0) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        eval_d = EVAL_CNT + 8'd1;
        if (EVAL_CNT == 8'd0) ref_d = PUF_OUT & mask_bits;
        else                  unst_d = UNSTABLE | ((PUF_OUT ^ PUF_OUT_REG) & mask_bits);
        if (eval_d == target_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = S_RST;
          phase_d = RST_LAST;
        end
      end
      S_DONE: begin
        if (CODE == 8'd4) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && CODE == 8'd0) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
    // Stimuli are decoded from the next state so they appear registered with the state.
    rst_x_d = (state_d == S_RST) ? mask_d : '0;
    i1_d    = (state_d == S_LAUNCH || state_d == S_EVAL) ? mask_d : '0;
    i2_d    = (state_d == S_EVAL) ? mask_d : '0;
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      target_q    <= 8'd0;
      err_pend_q  <= 1'b0;
      EVAL_CNT    <= 8'd0;
      PUF_OUT_REG <= '0;
      UNSTABLE    <= '0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      BUSY        <= 1'b0;
      RESET_XOR   <= '0;
      I1_XOR      <= '0;
      I2_XOR      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      target_q    <= target_d;
      err_pend_q  <= err_pend_d;
      EVAL_CNT    <= eval_d;
      PUF_OUT_REG <= ref_d;
      UNSTABLE    <= unst_d;
      DONE        <= done_d;
      ERR         <= err_d;
      BUSY        <= busy_d;
      RESET_XOR   <= rst_x_d;
      I1_XOR      <= i1_d;
      I2_XOR      <= i2_d;
    end
  end

endmodule

// File: tb/tb_xor_puf_ctrl_n.sv
// Directed bench for xor_puf_ctrl_n: driver pushes expected results, a DONE-edge monitor checks them.
module tb_xor_puf_ctrl_n;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [7:0]   CODE = 8'h01;
  logic [15:0]  CNT_VAL = '0;
  logic [7:0]   REP_VAL = '0;
  logic [3:0]   CH_MASK = '0;
  logic [127:0] PUF_OUT = '0;
  logic [3:0]   RESET_XOR, I1_XOR, I2_XOR;
  logic         BUSY, DONE, ERR;
  logic [7:0]   EVAL_CNT;
  logic [127:0] PUF_OUT_REG, UNSTABLE;

  xor_puf_ctrl_n #(.N_CH(4), .RESP_W(32), .CNT_W(16), .RST_CYC(2)) dut (
    .CLK(CLK), .RESET(RESET), .CODE(CODE), .CNT_VAL(CNT_VAL), .REP_VAL(REP_VAL),
    .CH_MASK(CH_MASK), .PUF_OUT(PUF_OUT), .RESET_XOR(RESET_XOR), .I1_XOR(I1_XOR),
    .I2_XOR(I2_XOR), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .EVAL_CNT(EVAL_CNT),
    .PUF_OUT_REG(PUF_OUT_REG), .UNSTABLE(UNSTABLE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int           lat;
    logic         err;
    logic [7:0]   ec;
    logic [127:0] ref_v;
    logic [127:0] unst;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   e0 = 0;

  localparam logic [127:0] PAT_A5   = {16{8'hA5}};
  localparam logic [127:0] PAT_BASE = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] PAT_M5   = 128'h00000000_FFFFFFFF_00000000_FFFFFFFF;
  localparam logic [127:0] PAT_LAST = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising DONE must match the oldest expected result.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (DONE && !done_prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got DONE=1 expected no result");
        end else begin
          e = sb.pop_front();
          chk("done_latency", 128'(cyc - e0), 128'(e.lat));
          chk("err", 128'(ERR), 128'(e.err));
          chk("eval_cnt", 128'(EVAL_CNT), 128'(e.ec));
          chk("puf_out_reg", PUF_OUT_REG, e.ref_v);
          chk("unstable", UNSTABLE, e.unst);
          chk("busy_at_done", 128'(BUSY), 128'(0));
        end
      end
      done_prev = DONE;
    end
  end

  task automatic start(input logic [7:0] code, input logic [15:0] cnt, input logic [7:0] rep,
                       input logic [3:0] mask);
    CODE = code; CNT_VAL = cnt; REP_VAL = rep; CH_MASK = mask;
    @(posedge CLK); #1;
    e0 = cyc;
    CODE = 8'h01;
  endtask

  task automatic wait_to(input int k);
    while (cyc < e0 + k) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_done(input int budget);
    int g;
    g = 0;
    while (!DONE && g < budget) begin
      @(posedge CLK); #1;
      g++;
    end
    n_checks++;
    if (!DONE) begin
      n_errors++;
      $display("FAIL done_timeout: got DONE=0 after %0d cycles expected DONE=1", budget);
    end
    @(negedge CLK);
    @(posedge CLK); #1;
  endtask

  task automatic ack();
    CODE = 8'h04;
    @(posedge CLK); #1;
    CODE = 8'h01;
    chk("ack_done", 128'(DONE), 128'(0));
    chk("ack_err", 128'(ERR), 128'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rst_xor"}, 128'(RESET_XOR), 128'(0));
    chk({tag, "_i1"}, 128'(I1_XOR), 128'(0));
    chk({tag, "_i2"}, 128'(I2_XOR), 128'(0));
    chk({tag, "_busy"}, 128'(BUSY), 128'(0));
    chk({tag, "_done"}, 128'(DONE), 128'(0));
    chk({tag, "_err"}, 128'(ERR), 128'(0));
    chk({tag, "_eval_cnt"}, 128'(EVAL_CNT), 128'(0));
    chk({tag, "_puf_out_reg"}, PUF_OUT_REG, 128'(0));
    chk({tag, "_unstable"}, UNSTABLE, 128'(0));
  endtask

  initial begin
    #12;
    chk_all_zero("reset");
    RESET = 1'b1;
    @(posedge CLK); #1;

    // Single run, CNT_VAL=10: 2 + 10 + 10 + 1 = 23 cycles.
    PUF_OUT = PAT_A5;
    sb.push_back('{lat: 23, err: 1'b0, ec: 8'd1, ref_v: PAT_A5, unst: '0});
    start(8'd2, 16'd10, 8'd0, 4'hF);
    chk("s1_busy_e0", 128'(BUSY), 128'(1));
    chk("s1_rstx_e0", 128'(RESET_XOR), 128'hF);
    chk("s1_i1_e0", 128'(I1_XOR), 128'h0);
    wait_to(1);  chk("s1_rstx_e1", 128'(RESET_XOR), 128'hF);
    wait_to(2);  chk("s1_rstx_e2", 128'(RESET_XOR), 128'h0);
    chk("s1_i1_e2", 128'(I1_XOR), 128'hF);
    chk("s1_i2_e2", 128'(I2_XOR), 128'h0);
    wait_to(11); chk("s1_i2_e11", 128'(I2_XOR), 128'h0);
    wait_to(12); chk("s1_i2_e12", 128'(I2_XOR), 128'hF);
    chk("s1_i1_e12", 128'(I1_XOR), 128'hF);
    wait_to(21); chk("s1_i2_e21", 128'(I2_XOR), 128'hF);
    wait_to(22); chk("s1_i1_sample", 128'(I1_XOR), 128'h0);
    chk("s1_busy_sample", 128'(BUSY), 128'(1));
    chk("s1_done_sample", 128'(DONE), 128'(0));
    wait_done(50);
    ack();
    chk("s1_held_ref", PUF_OUT_REG, PAT_A5);

    // Repeat run, 3 evaluations of 11 cycles; bit 0 differs only at sample 2.
    PUF_OUT = PAT_BASE;
    sb.push_back('{lat: 33, err: 1'b0, ec: 8'd3, ref_v: PAT_BASE, unst: 128'h1});
    start(8'd3, 16'd4, 8'd3, 4'hF);
    wait_to(11); PUF_OUT = PAT_BASE ^ 128'h1;
    chk("r_eval_cnt_1", 128'(EVAL_CNT), 128'(1));
    wait_to(22); PUF_OUT = PAT_BASE;
    chk("r_eval_cnt_2", 128'(EVAL_CNT), 128'(2));
    chk("r_rstx_eval2", 128'(RESET_XOR), 128'hF);
    wait_done(50);
    ack();

    // Partial mask: only channels 0 and 2 are driven and captured.
    PUF_OUT = '1;
    sb.push_back('{lat: 9, err: 1'b0, ec: 8'd1, ref_v: PAT_M5, unst: '0});
    start(8'd2, 16'd3, 8'd0, 4'b0101);
    chk("m_rstx", 128'(RESET_XOR), 128'h5);
    wait_to(2); chk("m_i1", 128'(I1_XOR), 128'h5);
    wait_to(5); chk("m_i2", 128'(I2_XOR), 128'h5);
    wait_done(30);
    ack();

    // Rejected starts: results from the previous run stay in place.
    sb.push_back('{lat: 1, err: 1'b1, ec: 8'd1, ref_v: PAT_M5, unst: '0});
    start(8'd2, 16'd0, 8'd0, 4'hF);
    chk("e1_busy_e0", 128'(BUSY), 128'(0));
    chk("e1_done_e0", 128'(DONE), 128'(0));
    chk("e1_rstx_e0", 128'(RESET_XOR), 128'h0);
    wait_done(5);
    ack();
    sb.push_back('{lat: 1, err: 1'b1, ec: 8'd1, ref_v: PAT_M5, unst: '0});
    start(8'd3, 16'd5, 8'd2, 4'h0);
    chk("e2_busy_e0", 128'(BUSY), 128'(0));
    chk("e2_rstx_e0", 128'(RESET_XOR), 128'h0);
    wait_done(5);
    ack();

    // Abort during EVAL.
    PUF_OUT = PAT_BASE;
    start(8'd2, 16'd5, 8'd0, 4'hF);
    wait_to(8);
    chk("ab_i2_eval", 128'(I2_XOR), 128'hF);
    CODE = 8'h00;
    @(posedge CLK); #1;
    CODE = 8'h01;
    chk("ab_i1", 128'(I1_XOR), 128'h0);
    chk("ab_i2", 128'(I2_XOR), 128'h0);
    chk("ab_busy", 128'(BUSY), 128'(0));
    chk("ab_done", 128'(DONE), 128'(0));
    chk("ab_eval_cnt", 128'(EVAL_CNT), 128'(0));
    repeat (20) @(posedge CLK);
    #1;
    chk("ab_done_later", 128'(DONE), 128'(0));

    // Asynchronous reset mid-LAUNCH, then a fresh run with CNT_VAL=2 (7 cycles).
    start(8'd2, 16'd10, 8'd0, 4'hF);
    wait_to(4);
    chk("ar_i1_launch", 128'(I1_XOR), 128'hF);
    #2 RESET = 1'b0;
    #1 chk_all_zero("async_rst");
    #3 RESET = 1'b1;
    @(posedge CLK); #1;
    PUF_OUT = PAT_LAST;
    sb.push_back('{lat: 7, err: 1'b0, ec: 8'd1, ref_v: PAT_LAST, unst: '0});
    start(8'd2, 16'd2, 8'd0, 4'hF);
    chk("pr_rstx_e0", 128'(RESET_XOR), 128'hF);
    wait_done(20);
    ack();

    repeat (3) @(posedge CLK);
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
